// File: rtl/seg_mode_ctrl.sv
// seg_mode_ctrl: mode sequencer and 8-digit multiplexed 7-segment arbiter.
// Debounces the mode/ack buttons, steps WATCH -> STOPWATCH -> ALARM_SET,
// lets an alarm ring preempt the display, and scans/decodes the digits with
// a short blanking window whenever the display source changes.
module seg_mode_ctrl #(
    parameter int DEB_CYCLES   = 20,
    parameter int SCAN_DIV     = 1,
    parameter int BLANK_CYCLES = 2,
    parameter int RING_CYCLES  = 10000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode_btn,
    input  logic        ack_btn,
    input  logic        alarm_hit,
    input  logic [31:0] watch_digits,
    input  logic [31:0] sw_digits,
    input  logic [31:0] alarm_digits,
    output logic [1:0]  state,
    output logic        ringing,
    output logic        mode_chg,
    output logic [7:0]  seg_data,
    output logic [7:0]  seg_com
);

    typedef enum logic [1:0] {
        WATCH     = 2'b00,
        STOPWATCH = 2'b01,
        ALARM_SET = 2'b10,
        ILLEGAL   = 2'b11
    } mode_t;

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int SW = $clog2(SCAN_DIV + 1);
    localparam int BW = $clog2(BLANK_CYCLES + 1);
    localparam int RW = $clog2(RING_CYCLES + 1);

    // ------------------------------------------------------------------
    // Button conditioning: bit 0 = mode, bit 1 = ack
    // ------------------------------------------------------------------
    logic [1:0] btn_raw;
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] deb;
    logic [1:0] deb_q;
    logic [1:0] btn_evt;
    logic       mode_evt;
    logic       ack_evt;

    assign btn_raw = {ack_btn, mode_btn};

    // Two-flop synchronizer for the asynchronous raw buttons
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_deb
        logic [DW-1:0] cnt;
        logic          level;

        // Flip the debounced level only after DEB_CYCLES consecutive differing samples
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt   <= '0;
                level <= 1'b0;
            end else if (sync2[b] != level) begin
                if (cnt == DW'(DEB_CYCLES - 1)) begin
                    level <= sync2[b];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + DW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end

        assign deb[b] = level;
    end

    // Delayed debounced level for rising-edge event detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_q <= '0;
        end else begin
            deb_q <= deb;
        end
    end

    assign btn_evt  = deb & ~deb_q;
    assign mode_evt = btn_evt[0];
    assign ack_evt  = btn_evt[1];

    // ------------------------------------------------------------------
    // Alarm ring: alarm_hit always wins (start or restart)
    // ------------------------------------------------------------------
    logic          ring_nxt;
    logic [RW-1:0] ring_cnt;
    logic [RW-1:0] ring_cnt_nxt;

    // Next ring state: load on hit, clear on ack or when the count runs out
    always_comb begin
        ring_nxt     = ringing;
        ring_cnt_nxt = ring_cnt;
        if (alarm_hit) begin
            ring_nxt     = 1'b1;
            ring_cnt_nxt = RW'(RING_CYCLES);
        end else if (ringing) begin
            if (ack_evt || ring_cnt <= RW'(1)) begin
                ring_nxt     = 1'b0;
                ring_cnt_nxt = '0;
            end else begin
                ring_cnt_nxt = ring_cnt - RW'(1);
            end
        end
    end

    // Ring state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ringing  <= 1'b0;
            ring_cnt <= '0;
        end else begin
            ringing  <= ring_nxt;
            ring_cnt <= ring_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Mode FSM: mode events are dropped while ringing or on an alarm hit
    // ------------------------------------------------------------------
    mode_t state_q;
    mode_t state_nxt;
    logic  mode_ok;
    logic  mode_adv;

    assign mode_ok = mode_evt && !ringing && !alarm_hit;

    // Mode state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= WATCH;
            mode_chg <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            mode_chg <= mode_adv;
        end
    end

    // Next mode; the unused encoding falls back to WATCH silently
    always_comb begin
        state_nxt = state_q;
        mode_adv  = 1'b0;
        case (state_q)
            WATCH: begin
                if (mode_ok) begin
                    state_nxt = STOPWATCH;
                    mode_adv  = 1'b1;
                end
            end
            STOPWATCH: begin
                if (mode_ok) begin
                    state_nxt = ALARM_SET;
                    mode_adv  = 1'b1;
                end
            end
            ALARM_SET: begin
                if (mode_ok) begin
                    state_nxt = WATCH;
                    mode_adv  = 1'b1;
                end
            end
            default: begin
                state_nxt = WATCH;
            end
        endcase
    end

    assign state = state_q;

    // ------------------------------------------------------------------
    // Display: source select, scan, decode, blanking
    // ------------------------------------------------------------------
    logic          src_chg;
    logic [31:0]   src;
    logic [3:0]    nib;
    logic [2:0]    idx;
    logic [SW-1:0] div_cnt;
    logic [BW-1:0] blank_cnt;

    assign src_chg = mode_adv || (ring_nxt != ringing);

    function automatic logic [7:0] seg_decode(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0:    s = 8'h3F;
            4'h1:    s = 8'h06;
            4'h2:    s = 8'h5B;
            4'h3:    s = 8'h4F;
            4'h4:    s = 8'h66;
            4'h5:    s = 8'h6D;
            4'h6:    s = 8'h7D;
            4'h7:    s = 8'h07;
            4'h8:    s = 8'h7F;
            4'h9:    s = 8'h6F;
            default: s = 8'h40;
        endcase
        return s;
    endfunction

    // Digit source: the ring always shows the watch time
    always_comb begin
        src = watch_digits;
        if (!ringing) begin
            case (state_q)
                STOPWATCH: src = sw_digits;
                ALARM_SET: src = alarm_digits;
                default:   src = watch_digits;
            endcase
        end
    end

    assign nib = src[{idx, 2'b00} +: 4];

    // Registered segment outputs; a source change (re)starts blanking and rewinds the scan
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_data  <= 8'h00;
            seg_com   <= 8'hFF;
            idx       <= '0;
            div_cnt   <= '0;
            blank_cnt <= '0;
        end else if (src_chg || blank_cnt != '0) begin
            seg_data  <= 8'h00;
            seg_com   <= 8'hFF;
            idx       <= '0;
            div_cnt   <= '0;
            blank_cnt <= src_chg ? BW'(BLANK_CYCLES - 1) : blank_cnt - BW'(1);
        end else begin
            seg_data <= seg_decode(nib) | {ringing, 7'b0};
            seg_com  <= ~(8'd1 << idx);
            if (div_cnt == SW'(SCAN_DIV - 1)) begin
                div_cnt <= '0;
                idx     <= idx + 3'd1;
            end else begin
                div_cnt <= div_cnt + SW'(1);
            end
        end
    end

endmodule
